uart_rx_mmio: RTL
=================

// Module: uart_rx_mmio
// PURPOSE
//  Serial-to-parallel UART receiver (8N1, LSB first) for the processor's
//  uart_rx_serial_input pin; counterpart of the datapath's transmitter.
//  Received bytes are buffered in a small FIFO and presented on a
//  memory-mapped read port that the datapath load path pops.
//  Sticky overrun/framing flags report loss to software.
// PARAMETERS
//  CLKS_PER_BIT  10417  clk cycles per bit (100 MHz / 9600 baud); >= 4
//  FIFO_DEPTH    16     receive FIFO entries; power of two, >= 2
// PORTS
//  clk                   in   1  system clock, rising edge
//  reset                 in   1  synchronous, active-high
//  uart_rx_serial_input  in   1  async serial line, idle high
//  rd_en                 in   1  pop head byte (ignored when rx_valid=0)
//  clr_err               in   1  clear overrun and frame_err
//  rd_data               out  8  FIFO head (first-word fall-through)
//  rx_valid              out  1  FIFO not empty
//  rx_count              out  $clog2(FIFO_DEPTH)+1  bytes held
//  overrun               out  1  sticky: byte dropped, FIFO full
//  frame_err             out  1  sticky: stop bit sampled low
// BEHAVIOUR
//  - Reset: FSM=IDLE, FIFO empty; rd_data=0, rx_valid=0, rx_count=0,
//    overrun=0, frame_err=0; synchronizer flops set to 1 (idle line).
//    Reset mid-frame abandons the frame; no partial byte is pushed.
//  - Input through 2-FF synchronizer; all decisions use synced value.
//  - Bit counter: $clog2(CLKS_PER_BIT) bits, wraps to 0 at CLKS_PER_BIT-1.
//  - FSM:
//    IDLE  : synced line low -> START, counter=0.
//    START : at count CLKS_PER_BIT/2 (floor): line low -> DATA, counter=0,
//            bit_idx=0; line high -> IDLE (glitch rejected, no flag).
//    DATA  : every CLKS_PER_BIT cycles sample into shift[bit_idx], LSB
//            first; after bit_idx 7 -> STOP.
//    STOP  : after CLKS_PER_BIT cycles sample: high -> push byte, IDLE;
//            low -> frame_err<=1, byte discarded, -> BREAK.
//    BREAK : wait for line high -> IDLE (no re-arm on a held-low line).
//  - Push latency: byte visible on rd_data, rx_valid=1 the cycle after
//    the stop-bit sample edge (empty FIFO case).
//  - Pop: rd_en & rx_valid advances head next edge; rd_en on empty is a
//    no-op, no flag.
//  - Push when full with no pop: byte dropped, overrun<=1. Push and pop in
//    same cycle when full: both succeed, count unchanged, no overrun.
//    Push and pop when count=1: count stays 1, rd_data = new byte.
//  - clr_err clears both flags; a set event in the same cycle wins.
//  - Pointers $clog2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; full/empty
//    from rx_count, never from pointer equality.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, START, DATA, STOP, BREAK),
//    UART_DATA_BITS=8, default CLKS_PER_BIT; the datapath transmitter
//    shares the same constants.
//  - One sub-module: uart_rx_fifo (sync FWFT FIFO, DEPTH param, push/pop,
//    full/empty/count). FSM, synchronizer, counters and flags in top.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Send 0xA5 8N1 -> rx_valid=1 one cycle after stop sample, rd_data=0xA5,
//    flags 0; rd_en one cycle -> rx_valid=0, rx_count=0.
//  2 Low pulse of 1 cycle on idle line -> FSM back to IDLE, rx_valid=0,
//    no flags.
//  3 Send 0x3C with stop bit low, then hold line low 20 cycles, then high,
//    then send 0x11 -> frame_err=1, only 0x11 in FIFO; clr_err -> 0.
//  4 Send 0x01..0x05 without reading -> rx_count=4, overrun=1, pops yield
//    0x01,0x02,0x03,0x04.
//  5 FIFO full, rd_en asserted on push cycle of 0x55 -> overrun=0, count 4,
//    0x55 read last.
//  6 Assert reset during DATA of 0xFF -> all outputs 0; next frame 0x5A
//    received correctly.

Source files
------------

// File: rtl/uart_rx_mmio_pkg.sv
// Shared UART constants and receiver FSM encoding.
// The datapath transmitter imports the same bit-timing constants.
package uart_rx_mmio_pkg;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 10417;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// Full/empty come from the occupancy count, not pointer equality.
module uart_rx_fifo
   import uart_rx_mmio_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // A pop frees the head slot, so a push into a full FIFO still lands.
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with FWFT byte FIFO and sticky error flags,
// exposed as a memory-mapped read port for the load path.
module uart_rx_mmio
   import uart_rx_mmio_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          uart_rx_serial_input,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [7:0]                    rd_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          overrun,
   output logic                          frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(UART_DATA_BITS);

   localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

   uart_state_e         state_q, state_d;
   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]       bit_idx_q, bit_idx_d;
   logic [7:0]          shift_q, shift_d;
   logic                overrun_q, overrun_d;
   logic                frame_err_q, frame_err_d;
   logic                rx_s;
   logic                push, fe_set, drop;
   logic                fifo_full, fifo_empty;

   assign sync1_d = uart_rx_serial_input;
   assign sync2_d = sync1_q;
   assign rx_s    = sync2_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      fe_set    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d              = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
               else bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  fe_set  = 1'b1;
                  state_d = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Held-low line must return high before a new start is armed.
         ST_BREAK: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Set events take priority over a same-cycle clear.
   always_comb begin
      drop        = push & fifo_full & ~rd_en;
      overrun_d   = drop   | (overrun_q   & ~clr_err);
      frame_err_d = fe_set | (frame_err_q & ~clr_err);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data (shift_q),
      .pop     (rd_en),
      .rd_data (rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (rx_count)
   );

   assign rx_valid  = ~fifo_empty;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule
